idex_hazard_stage: RTL and testbench

- ID/EX pipeline register for the 8-register CPU core, combined with load-use hazard detection.
- Captures decoded operands and control from ID each cycle.
- Drives the idex_rs/idex_rt/idex_rd and regWrite/memRead signals consumed by the EX-stage forwarding unit and the EX/MEM register.
- Inserts one-cycle bubbles on load-use hazards and on branch flush, and stalls the upstream PC and IF/ID register.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/load_use_detect.sv | 25 ++
 rtl/idex_hazard_stage.sv | 175 +++++++++++++++++
 tb/tb_idex_hazard_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 8-register CPU core pipeline.
// Control bundle, ALU opcodes and ID/EX stage state encoding.
package cpu_pkg;

    localparam int REG_W   = 3;
    localparam int DATA_W  = 16;
    localparam int ALUOP_W = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } aluop_t;

    typedef struct packed {
        logic   regWrite;
        logic   memRead;
        logic   memWrite;
        logic   memToReg;
        logic   aluSrc;
        aluop_t aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_BUBBLE = 1'b1
    } idex_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between ID and the ID/EX register.
// Register 0 is an ordinary register, so it is compared like any other.
module load_use_detect #(
    parameter int REG_W = 3
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_memRead,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    output logic             o_hazard
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_id_uses_rs & (i_id_rs == i_ex_rd);
    assign w_rt_hit = i_id_uses_rt & (i_id_rt == i_ex_rd);
    assign o_hazard = i_ex_valid & i_ex_memRead & i_id_valid
                    & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall and branch-flush bubbles.
// Optional macro IDEX_BUBBLE_CNT_EN adds saturating bubble/flush counters.
import cpu_pkg::*;

module idex_hazard_stage #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int REG_W   = cpu_pkg::REG_W,
    parameter int ALUOP_W = cpu_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_read_data_1,
    input  logic [DATA_W-1:0]  id_read_data_2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_regWrite,
    input  logic               id_memRead,
    input  logic               id_memWrite,
    input  logic               id_memToReg,
    input  logic               id_aluSrc,
    input  logic [ALUOP_W-1:0] id_aluOp,
    input  logic               flush,
    output logic               stall_if,
`ifdef IDEX_BUBBLE_CNT_EN
    output logic [15:0]        bubble_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic               idex_valid,
    output logic [REG_W-1:0]   idex_rs,
    output logic [REG_W-1:0]   idex_rt,
    output logic [REG_W-1:0]   idex_rd,
    output logic [DATA_W-1:0]  idex_read_data_1,
    output logic [DATA_W-1:0]  idex_read_data_2,
    output logic [DATA_W-1:0]  idex_imm,
    output logic               idex_regWrite,
    output logic               idex_memRead,
    output logic               idex_memWrite,
    output logic               idex_memToReg,
    output logic               idex_aluSrc,
    output logic [ALUOP_W-1:0] idex_aluOp
);

    idex_state_t       r_state;
    logic              r_valid;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    ctrl_t             r_ctrl;

    logic  w_hazard_raw;
    logic  w_hazard;
    logic  w_bubble;
    ctrl_t w_id_ctrl;

    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .i_ex_valid   (r_valid),
        .i_ex_memRead (r_ctrl.memRead),
        .i_ex_rd      (r_rd),
        .i_id_valid   (id_valid),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rs (id_uses_rs),
        .i_id_uses_rt (id_uses_rt),
        .o_hazard     (w_hazard_raw)
    );

    // A bubble carries memRead=0, so a hazard can only be raised from NORMAL.
    assign w_hazard = w_hazard_raw & (r_state == ST_NORMAL);
    assign w_bubble = flush | w_hazard;
    assign stall_if = w_hazard & ~flush & ~rst;

    // Decoded control, zeroed when ID holds no real instruction.
    always_comb begin
        w_id_ctrl = CTRL_BUBBLE;
        if (id_valid) begin
            w_id_ctrl.regWrite = id_regWrite;
            w_id_ctrl.memRead  = id_memRead;
            w_id_ctrl.memWrite = id_memWrite;
            w_id_ctrl.memToReg = id_memToReg;
            w_id_ctrl.aluSrc   = id_aluSrc;
            w_id_ctrl.aluOp    = aluop_t'(id_aluOp);
        end
    end

    // NORMAL/BUBBLE tracking: any inserted bubble lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else if (w_bubble) begin
            r_state <= ST_BUBBLE;
        end else begin
            r_state <= ST_NORMAL;
        end
    end

    // ID/EX register: flush first, then load-use bubble, else capture ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_valid <= id_valid;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_rd    <= id_rd;
            r_rd1   <= id_read_data_1;
            r_rd2   <= id_read_data_2;
            r_imm   <= id_imm;
            r_ctrl  <= w_id_ctrl;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_flush_cnt;

    // Saturating event counters for load-use bubbles and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_hazard && !flush && r_bubble_cnt != 16'hFFFF) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
            if (flush && r_flush_cnt != 16'hFFFF) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

    assign idex_valid       = r_valid;
    assign idex_rs          = r_rs;
    assign idex_rt          = r_rt;
    assign idex_rd          = r_rd;
    assign idex_read_data_1 = r_rd1;
    assign idex_read_data_2 = r_rd2;
    assign idex_imm         = r_imm;
    assign idex_regWrite    = r_ctrl.regWrite;
    assign idex_memRead     = r_ctrl.memRead;
    assign idex_memWrite    = r_ctrl.memWrite;
    assign idex_memToReg    = r_ctrl.memToReg;
    assign idex_aluSrc      = r_ctrl.aluSrc;
    assign idex_aluOp       = r_ctrl.aluOp;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Self-checking bench for idex_hazard_stage.
// Scoreboard of expected ID/EX contents plus directed hazard scenarios.
module tb_idex_hazard_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt;
    logic [15:0] id_read_data_1, id_read_data_2, id_imm;
    logic        id_regWrite, id_memRead, id_memWrite;
    logic        id_memToReg, id_aluSrc;
    logic [2:0]  id_aluOp;
    logic        flush;
    logic        stall_if;
    logic        idex_valid;
    logic [2:0]  idex_rs, idex_rt, idex_rd;
    logic [15:0] idex_read_data_1, idex_read_data_2, idex_imm;
    logic        idex_regWrite, idex_memRead, idex_memWrite;
    logic        idex_memToReg, idex_aluSrc;
    logic [2:0]  idex_aluOp;
`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    idex_hazard_stage dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .id_read_data_1   (id_read_data_1),
        .id_read_data_2   (id_read_data_2),
        .id_imm           (id_imm),
        .id_regWrite      (id_regWrite),
        .id_memRead       (id_memRead),
        .id_memWrite      (id_memWrite),
        .id_memToReg      (id_memToReg),
        .id_aluSrc        (id_aluSrc),
        .id_aluOp         (id_aluOp),
        .flush            (flush),
        .stall_if         (stall_if),
`ifdef IDEX_BUBBLE_CNT_EN
        .bubble_cnt       (bubble_cnt),
        .flush_cnt        (flush_cnt),
`endif
        .idex_valid       (idex_valid),
        .idex_rs          (idex_rs),
        .idex_rt          (idex_rt),
        .idex_rd          (idex_rd),
        .idex_read_data_1 (idex_read_data_1),
        .idex_read_data_2 (idex_read_data_2),
        .idex_imm         (idex_imm),
        .idex_regWrite    (idex_regWrite),
        .idex_memRead     (idex_memRead),
        .idex_memWrite    (idex_memWrite),
        .idex_memToReg    (idex_memToReg),
        .idex_aluSrc      (idex_aluSrc),
        .idex_aluOp       (idex_aluOp)
    );

    typedef struct packed {
        logic        v;
        logic [2:0]  rs, rt, rd;
        logic [15:0] d1, d2, imm;
        logic        rw, mr, mw, mtr, as;
        logic [2:0]  op;
    } snap_t;

    snap_t q[$];
    snap_t m;
    int    checks = 0;
    int    fails  = 0;
    int    m_bub  = 0;
    int    m_fl   = 0;
    logic  st;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic snap_t obs();
        snap_t s;
        s = {idex_valid, idex_rs, idex_rt, idex_rd,
             idex_read_data_1, idex_read_data_2, idex_imm,
             idex_regWrite, idex_memRead, idex_memWrite,
             idex_memToReg, idex_aluSrc, idex_aluOp};
        return s;
    endfunction

    function automatic logic mhaz();
        return m.v & m.mr & id_valid &
               ((id_uses_rs & (id_rs == m.rd)) |
                (id_uses_rt & (id_rt == m.rd)));
    endfunction

    task automatic set_id(input logic v, input logic [2:0] rs, rt, rd,
                          input logic urs, urt, input logic [15:0] d1, imm,
                          input logic rw, mr, mtr, input logic [2:0] op,
                          input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_read_data_1 = d1; id_read_data_2 = d1 ^ 16'h0F0F;
        id_imm = imm; id_regWrite = rw; id_memRead = mr;
        id_memWrite = 1'b0; id_memToReg = mtr; id_aluSrc = mr;
        id_aluOp = op; flush = fl;
    endtask

    // Called at a negedge with inputs set; returns the sampled stall_if.
    task automatic cyc(input string tag, output logic st_dut);
        snap_t e, g;
        logic  hz;
        #1;
        hz = mhaz();
        st_dut = stall_if;
        chk({tag, "_stall"}, stall_if, hz & ~flush);
        if (flush || hz) begin
            e = '0;
        end else begin
            e = {id_valid, id_rs, id_rt, id_rd, id_read_data_1,
                 id_read_data_2, id_imm, id_regWrite, id_memRead,
                 id_memWrite, id_memToReg, id_aluSrc, id_aluOp};
            if (!id_valid) begin
                e.rw = 0; e.mr = 0; e.mw = 0; e.mtr = 0; e.as = 0;
                e.op = '0;
            end
        end
        if (hz && !flush) m_bub++;
        if (flush) m_fl++;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = obs();
        e = q.pop_front();
        chk(tag, g, e);
        m = e;
        @(negedge clk);
    endtask

    task automatic load(input logic [2:0] rd);
        set_id(1, 3'd1, 3'd2, rd, 1, 0, 16'h1111, 16'h0010, 1, 1, 1, 3'd0, 0);
        cyc("load", st);
        chk("load_mr", {idex_memRead, idex_rd}, {1'b1, rd});
    endtask

    initial begin
        m = '0;
        set_id(1, 3'd7, 3'd6, 3'd5, 1, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 3'd7, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_out", obs(), '0);
        chk("rst_stall", stall_if, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hold", obs(), '0);

        // Pass-through
        set_id(1, 3'd1, 3'd2, 3'd3, 1, 1, 16'hA5A5, 16'h0007, 1, 0, 0, 3'd2, 0);
        cyc("pass", st);
        chk("pass_rs", idex_rs, 3'd1);
        chk("pass_d1", idex_read_data_1, 16'hA5A5);
        chk("pass_rw_v", {idex_regWrite, idex_valid}, 2'b11);

        // Load-use: one stall, one bubble, then the dependent advances
        load(3'd4);
        set_id(1, 3'd4, 3'd5, 3'd6, 1, 0, 16'h2222, 16'h0000, 1, 0, 0, 3'd1, 0);
        cyc("lu1", st);
        chk("lu_stall1", st, 1'b1);
        chk("lu_bubble", {idex_valid, idex_regWrite}, 2'b00);
        cyc("lu2", st);
        chk("lu_stall2", st, 1'b0);
        chk("lu_adv", {idex_valid, idex_rs}, {1'b1, 3'd4});

        // Unused rt matching the load destination must not stall
        load(3'd4);
        set_id(1, 3'd1, 3'd4, 3'd7, 1, 0, 16'h3333, 16'h0001, 1, 0, 0, 3'd3, 0);
        cyc("nofalse", st);
        chk("nofalse_st", st, 1'b0);
        chk("nofalse_adv", {idex_valid, idex_rd}, {1'b1, 3'd7});

        // Flush beats hazard
        load(3'd4);
        set_id(1, 3'd4, 3'd4, 3'd2, 1, 1, 16'h4444, 16'h0002, 1, 0, 0, 3'd4, 1);
        cyc("flush", st);
        chk("flush_st", st, 1'b0);
        chk("flush_bub", {idex_valid, idex_regWrite, idex_memRead}, 3'b000);
        set_id(1, 3'd2, 3'd3, 3'd1, 1, 1, 16'h5555, 16'h0003, 1, 0, 0, 3'd5, 0);
        cyc("postfl", st);
        chk("postfl_adv", {idex_valid, idex_rd}, {1'b1, 3'd1});

        // Back-to-back loads: each dependent costs one bubble
        load(3'd5);
        set_id(1, 3'd5, 3'd0, 3'd6, 1, 0, 16'h6666, 16'h0004, 1, 1, 1, 3'd0, 0);
        cyc("b2b_a", st);
        chk("b2b_st_a", st, 1'b1);
        cyc("b2b_b", st);
        chk("b2b_ld_b", {idex_memRead, idex_rd}, {1'b1, 3'd6});
        set_id(1, 3'd0, 3'd6, 3'd3, 0, 1, 16'h7777, 16'h0005, 1, 0, 0, 3'd6, 0);
        cyc("b2b_c", st);
        chk("b2b_st_c", st, 1'b1);
        cyc("b2b_d", st);
        chk("b2b_adv", {idex_valid, idex_rd}, {1'b1, 3'd3});

        // Register 0 destination is compared
        load(3'd0);
        set_id(1, 3'd3, 3'd0, 3'd2, 0, 1, 16'h8888, 16'h0006, 1, 0, 0, 3'd7, 0);
        cyc("r0_a", st);
        chk("r0_st", st, 1'b1);
        cyc("r0_b", st);

        // Invalid ID instruction: control forced to zero, data still captured
        set_id(0, 3'd1, 3'd1, 3'd1, 1, 1, 16'h9999, 16'h0008, 1, 1, 1, 3'd5, 0);
        cyc("inval", st);
        chk("inval_ctl", {idex_valid, idex_regWrite, idex_memRead}, 3'b000);
        chk("inval_d1", idex_read_data_1, 16'h9999);

        // Second flush cycle, no hazard present
        set_id(1, 3'd1, 3'd2, 3'd3, 1, 1, 16'hABCD, 16'h0009, 1, 0, 0, 3'd0, 1);
        cyc("flush2", st);

`ifdef IDEX_BUBBLE_CNT_EN
        chk("bubble_cnt", bubble_cnt, 16'(m_bub));
        chk("flush_cnt", flush_cnt, 16'(m_fl));
        chk("bubble_cnt_k", bubble_cnt, 16'd4);
        chk("flush_cnt_k", flush_cnt, 16'd2);
`endif

        // Reset in the middle of a stall
        load(3'd2);
        set_id(1, 3'd2, 3'd0, 3'd4, 1, 0, 16'hCAFE, 16'h000A, 1, 0, 0, 3'd1, 0);
        #1;
        chk("mrst_pre", stall_if, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_stall", stall_if, 1'b0);
        chk("mrst_out", obs(), '0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("mrst_hold", {obs(), stall_if}, '0);
        end
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_rel", obs(), '0);
        q.delete();
        m = '0;
        m_bub = 0;
        m_fl = 0;
`ifdef IDEX_BUBBLE_CNT_EN
        chk("cnt_rst", {bubble_cnt, flush_cnt}, 32'd0);
`endif
        cyc("post_rst", st);
        chk("post_rst_adv", {idex_valid, idex_rs}, {1'b1, 3'd2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
